pin_lockout_ctrl: RTL
=====================

Name: pin_lockout_ctrl

Overview:
- Sits directly downstream of the PIN checker: consumes its correct/incorrect result levels and counts consecutive failed attempts.
- After MAX_TRIES consecutive failures it enters a timed lockout.
- During lockout it gates the user submit strobe, so the checker receives no new entries until the lockout expires.
- Exposes lock status, the attempts remaining and the lockout countdown for LEDs and the display.

Parameters:
- MAX_TRIES, 3, consecutive incorrect results that trigger lockout; legal range 1..7.
- LOCK_CYCLES, 1000, base lockout duration in clk cycles; legal range >= 2.
- LOCK_W, 16, width of the lockout counter; must hold LOCK_CYCLES*8 when the optional feature is enabled.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- submit_in  in  1  one-cycle submit strobe from the user button logic.
- correct  in  1  checker result level; may stay high for many cycles.
- incorrect  in  1  checker result level; may stay high for many cycles.
- submit_out  out  1  gated submit strobe to the checker (registered).
- locked  out  1  high while lockout is active.
- attempts_left  out  3  MAX_TRIES minus the current consecutive-failure count.
- lock_remaining  out  LOCK_W  lockout cycles remaining; 0 when not locked.
- unlocked_pulse  out  1  one-cycle strobe when a lockout expires.

Behaviour:
- Reset values (asynchronous, active-high):
  - state=ARMED, fail_cnt=0, lock_remaining=0, locked=0, submit_out=0, unlocked_pulse=0, attempts_left=MAX_TRIES.
  - Edge-detect registers (correct_q, incorrect_q) clear to 0.
- Edge detection:
  - correct_q and incorrect_q register the inputs every cycle.
  - rise_c = correct & ~correct_q; rise_i = incorrect & ~incorrect_q.
  - Only rising edges are events; a held level counts once.
- attempts_left = MAX_TRIES - fail_cnt, registered alongside fail_cnt.
- State ARMED:
  - submit_out <= submit_in (1-cycle latency, no other change).
  - rise_c: fail_cnt <= 0.
  - rise_i with fail_cnt < MAX_TRIES-1: fail_cnt <= fail_cnt+1.
  - rise_i with fail_cnt == MAX_TRIES-1: next state LOCKED.
    - fail_cnt <= MAX_TRIES, so attempts_left = 0.
    - lock_remaining <= lockout duration; locked <= 1 on the same edge.
  - rise_c and rise_i in the same cycle: treated as incorrect (fail-safe).
- State LOCKED:
  - submit_out held 0; submit_in strobes are dropped, not queued.
  - correct and incorrect edges are ignored (fail_cnt unchanged).
  - lock_remaining decrements by 1 each cycle.
  - When lock_remaining == 1 and decrements:
    - lock_remaining <= 0, locked <= 0, fail_cnt <= 0, unlocked_pulse <= 1 for exactly one cycle, next state ARMED.
  - locked is therefore high for exactly `duration` cycles.
- submit_in in the cycle locked rises: dropped (submit_out stays 0).
- submit_in in the final locked cycle: dropped. The first passed strobe is one sampled in ARMED.
- No wrap-around:
  - fail_cnt saturates at MAX_TRIES.
  - lock_remaining never decrements below 0.
- Reset mid-lockout: immediately ARMED, counters cleared, no unlocked_pulse.
- Lockout duration = LOCK_CYCLES unless the optional feature is enabled.

Optional Feature:
- Macro: PIN_LOCKOUT_ESCALATE_EN.
- Defined:
  - 2-bit lock_level register, reset 0.
  - Duration = LOCK_CYCLES << lock_level.
  - lock_level increments, saturating at 3, each time LOCKED is entered (after the duration is computed).
  - lock_level clears to 0 on an accepted rise_c in ARMED.
- Undefined: no lock_level register; duration is always LOCK_CYCLES.

Test Plan:
Bench parameters: MAX_TRIES=3, LOCK_CYCLES=8.
1. Reset, then one submit_in pulse -> submit_out high exactly one cycle later; locked=0; attempts_left=3.
2. Two incorrect pulses, each held 5 cycles -> attempts_left 3->2->1; a held level decrements only once.
3. Third incorrect rising edge -> locked=1 next cycle, lock_remaining=8 counting down to 1; locked high for exactly 8 cycles; unlocked_pulse for 1 cycle; attempts_left=3.
4. submit_in pulsed every cycle during lockout -> submit_out stays 0 throughout; first submit_in in ARMED passes.
5. Two incorrect, then correct -> attempts_left back to 3; same-cycle correct+incorrect rise -> counted as incorrect (attempts_left 3->2).
6. Reset asserted mid-lockout at lock_remaining=4 -> locked=0 and lock_remaining=0 immediately, no unlocked_pulse. With PIN_LOCKOUT_ESCALATE_EN: successive lockouts last 8, 16, 32, 64, 64 cycles; a correct result restores 8.

Source files
------------

// File: rtl/pin_lockout_ctrl_if.sv
// pin_lockout_ctrl_if: bundles the user/checker handshake of pin_lockout_ctrl.
// The master side drives the submit strobe and checker result levels.
// The slave side (the lockout controller) drives the gated strobe and status.
interface pin_lockout_ctrl_if #(
    parameter int LOCK_W = 16
);
    logic              submit_in;
    logic              correct;
    logic              incorrect;
    logic              submit_out;
    logic              locked;
    logic [2:0]        attempts_left;
    logic [LOCK_W-1:0] lock_remaining;
    logic              unlocked_pulse;

    modport master (
        output submit_in, correct, incorrect,
        input  submit_out, locked, attempts_left, lock_remaining, unlocked_pulse
    );

    modport slave (
        input  submit_in, correct, incorrect,
        output submit_out, locked, attempts_left, lock_remaining, unlocked_pulse
    );
endinterface

// File: rtl/pin_lockout_ctrl.sv
// pin_lockout_ctrl: counts consecutive failed PIN attempts from the checker
// and enforces a timed lockout that gates the user submit strobe.
// Optional macro PIN_LOCKOUT_ESCALATE_EN doubles the lockout duration on each
// successive lockout (up to 8x) until a correct result is accepted.
module pin_lockout_ctrl #(
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 1000,
    parameter int LOCK_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    pin_lockout_ctrl_if.slave bus
);
    typedef enum logic {
        ARMED  = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [2:0]        MAX_T  = 3'(MAX_TRIES);
    localparam logic [2:0]        LAST_T = 3'(MAX_TRIES - 1);
    localparam logic [LOCK_W-1:0] BASE   = LOCK_W'(LOCK_CYCLES);
    localparam logic [LOCK_W-1:0] ONE    = LOCK_W'(1);

    state_t            state, state_next;
    logic [2:0]        fail_cnt, fail_next;
    logic [2:0]        attempts_q, attempts_next;
    logic [LOCK_W-1:0] lock_rem, rem_next;
    logic              submit_q, submit_next;
    logic              unlock_q, unlock_next;
    logic              correct_q, incorrect_q;
    logic              rise_c, rise_i, accept_c;
    logic              enter_lock, clear_level;
    logic [LOCK_W-1:0] duration;

    assign rise_c   = bus.correct & ~correct_q;
    assign rise_i   = bus.incorrect & ~incorrect_q;
    // Simultaneous correct+incorrect edges count as a failure (fail-safe).
    assign accept_c = rise_c & ~rise_i;

    assign enter_lock  = (state == ARMED) && rise_i && (fail_cnt >= LAST_T);
    assign clear_level = (state == ARMED) && accept_c;

`ifdef PIN_LOCKOUT_ESCALATE_EN
    logic [1:0] lock_level;

    assign duration = BASE << lock_level;

    // Escalation level: bumps on each lockout entry, clears on an accepted pass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_level <= 2'd0;
        end else if (enter_lock) begin
            if (lock_level != 2'd3) lock_level <= lock_level + 2'd1;
        end else if (clear_level) begin
            lock_level <= 2'd0;
        end
    end
`else
    assign duration = BASE;
`endif

    // State and datapath registers, including the checker-level edge detectors.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values; blocking would create order-dependent races.
        if (reset) begin
            state       <= ARMED;
            fail_cnt    <= 3'd0;
            attempts_q  <= MAX_T;
            lock_rem    <= '0;
            submit_q    <= 1'b0;
            unlock_q    <= 1'b0;
            correct_q   <= 1'b0;
            incorrect_q <= 1'b0;
        end else begin
            state       <= state_next;
            fail_cnt    <= fail_next;
            attempts_q  <= attempts_next;
            lock_rem    <= rem_next;
            submit_q    <= submit_next;
            unlock_q    <= unlock_next;
            correct_q   <= bus.correct;
            incorrect_q <= bus.incorrect;
        end
    end

    // Next-state: lock on the final failure, re-arm when the countdown ends.
    always_comb begin
        state_next = state;
        case (state)
            ARMED:   if (enter_lock) state_next = LOCKED;
            LOCKED:  if (lock_rem <= ONE) state_next = ARMED;
            default: state_next = ARMED;
        endcase
    end

    // Output/datapath next values for the registered outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        fail_next   = fail_cnt;
        rem_next    = lock_rem;
        submit_next = 1'b0;
        unlock_next = 1'b0;
        case (state)
            ARMED: begin
                submit_next = bus.submit_in;
                if (enter_lock) begin
                    fail_next = MAX_T;
                    rem_next  = duration;
                end else if (rise_i) begin
                    fail_next = fail_cnt + 3'd1;
                end else if (accept_c) begin
                    fail_next = 3'd0;
                end
            end
            LOCKED: begin
                // Strobes and checker edges are dropped while locked.
                if (lock_rem > ONE) begin
                    rem_next = lock_rem - ONE;
                end else begin
                    rem_next    = '0;
                    fail_next   = 3'd0;
                    unlock_next = 1'b1;
                end
            end
            default: ;
        endcase
        attempts_next = MAX_T - fail_next;
    end

    assign bus.submit_out     = submit_q;
    assign bus.locked         = (state == LOCKED);
    assign bus.attempts_left  = attempts_q;
    assign bus.lock_remaining = lock_rem;
    assign bus.unlocked_pulse = unlock_q;
endmodule
